// File: rtl/snn_to_ann_decoder.sv
// rtl/snn_to_ann_decoder.sv - rate-code spike train to ANN activation decoder
//
// Purpose:
//   Accepts one T-bit spike train (bit 0 = earliest timestep) from the
//   upstream encoder. It walks the train one timestep per clock and counts
//   the spikes. It then presents count * THRESHOLD on a valid/ready output.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   spike_in     T-bit spike train, sampled only on acceptance in IDLE
//   spike_valid  spike_in is valid
//   spike_ready  decoder is idle and can accept a train
//   data_out     decoded activation (keeps last value after handshake)
//   data_valid   data_out is valid, held until data_ready
//   data_ready   downstream accepts data_out
//   busy         decoder is not idle
//
// Optional feature:
//   SNN_DECODE_SAT_EN  when defined, products above 2^OUT_WIDTH-1 saturate to
//                      all ones; otherwise the low OUT_WIDTH bits are kept.
module snn_to_ann_decoder #(
  parameter int T         = 4,
  parameter int THRESHOLD = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [T-1:0]         spike_in,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(T + 1);
  localparam int T_W    = (T > 1) ? $clog2(T) : 1;
  localparam int PROD_W = $clog2(T + 1) + $clog2(THRESHOLD + 1);
  // Product is evaluated at least OUT_WIDTH wide so that both the wrap and
  // saturate paths can slice/compare without width juggling.
  localparam int EXT_W  = (PROD_W > OUT_WIDTH) ? PROD_W : OUT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [T-1:0]           sh_q, sh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [T_W-1:0]         t_q, t_d;
  logic [OUT_WIDTH-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;

  logic [CNT_W-1:0]       cnt_final;
  logic [EXT_W-1:0]       prod;
  logic [OUT_WIDTH-1:0]   reduced;
  logic                   prod_unused;

  // The current timestep's spike is folded in here so the last ACCUM cycle
  // can register the finished product without an extra cycle.
  assign cnt_final = cnt_q + CNT_W'(sh_q[0]);
  assign prod      = EXT_W'(cnt_final) * EXT_W'(THRESHOLD);

`ifdef SNN_DECODE_SAT_EN
  assign reduced = (prod > EXT_W'({OUT_WIDTH{1'b1}})) ? {OUT_WIDTH{1'b1}}
                                                      : prod[OUT_WIDTH-1:0];
`else
  assign reduced = prod[OUT_WIDTH-1:0];
`endif

  // Upper product bits are intentionally dropped in the wrapping build.
  assign prod_unused = ^prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      t_q          <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      t_q          <= t_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    t_d          = t_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;

    case (state_q)
      IDLE: begin
        if (spike_valid) begin
          sh_d    = spike_in;
          cnt_d   = '0;
          t_d     = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        sh_d  = sh_q >> 1;
        cnt_d = cnt_final;
        t_d   = t_q + T_W'(1);
        if (t_q == T_W'(T - 1)) begin
          data_out_d   = reduced;
          data_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        if (data_ready) begin
          data_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spike_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_snn_to_ann_decoder.sv
// tb/tb_snn_to_ann_decoder.sv - directed and randomised checks of snn_to_ann_decoder
`timescale 1ns/1ps
module tb_snn_to_ann_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance: T=4, THRESHOLD=8, OUT_WIDTH=8.
  logic [3:0] spike_in;
  logic       spike_valid;
  logic       spike_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;

  // Narrow-output instance: OUT_WIDTH=5.
  logic [3:0] n_spike_in;
  logic       n_spike_valid;
  logic       n_spike_ready;
  logic [4:0] n_data_out;
  logic       n_data_valid;
  logic       n_data_ready;
  logic       n_busy;

`ifdef SNN_DECODE_SAT_EN
  localparam int NARROW_1111 = 31;
`else
  localparam int NARROW_1111 = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  snn_to_ann_decoder #(.T(4), .THRESHOLD(8), .OUT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .spike_in    (spike_in),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy)
  );

  snn_to_ann_decoder #(.T(4), .THRESHOLD(8), .OUT_WIDTH(5)) dut_narrow (
    .clk         (clk),
    .rst         (rst),
    .spike_in    (n_spike_in),
    .spike_valid (n_spike_valid),
    .spike_ready (n_spike_ready),
    .data_out    (n_data_out),
    .data_valid  (n_data_valid),
    .data_ready  (n_data_ready),
    .busy        (n_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a train and return once the acceptance edge has passed.
  task automatic offer(input logic [3:0] s, output int acc_cyc);
    int w = 0;
    spike_in    = s;
    spike_valid = 1'b1;
    while (!spike_ready && w < 100) begin
      step();
      w++;
    end
    checks++;
    if (spike_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_timeout spike_ready=%0b required 1", spike_ready);
    end
    step();
    acc_cyc     = cyc;
    spike_valid = 1'b0;
    spike_in    = '0;
  endtask

  task automatic wait_valid(input int acc_cyc, output int lat);
    int w = 0;
    while (!data_valid && w < 100) begin
      step();
      w++;
    end
    lat = cyc - acc_cyc;
    checks++;
    if (data_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_timeout data_valid=%0b required 1", data_valid);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    spike_in      = '0;
    spike_valid   = 1'b0;
    data_ready    = 1'b1;
    n_spike_in    = '0;
    n_spike_valid = 1'b0;
    n_data_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 8'd0) begin
      errors++; $display("FAIL reset_data_out got %0d required 0", data_out);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_data_valid got %0b required 0", data_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b required 0", busy);
    end
    checks++;
    if (spike_ready !== 1'b1) begin
      errors++; $display("FAIL reset_spike_ready got %0b required 1", spike_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int acc;
    int lat = -1;
    int busy_n = 0;
    logic [7:0] dval = '0;
    data_ready = 1'b1;
    offer(4'b1111, acc);
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_n++;
      if (data_valid && lat < 0) begin
        lat  = cyc - acc;
        dval = data_out;
      end
      if (!busy) break;
      step();
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL basic_latency got %0d required 4", lat);
    end
    checks++;
    if (dval !== 8'd32) begin
      errors++; $display("FAIL basic_data_out got %0d required 32", dval);
    end
    checks++;
    if (busy_n != 5) begin
      errors++; $display("FAIL basic_busy_cycles got %0d required 5", busy_n);
    end
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, lat;
    int w = 0;
    logic got0 = 1'b0;
    logic [7:0] d0 = 8'hff;
    data_ready = 1'b1;
    offer(4'b0000, acc0);
    // Next train is presented immediately and must wait for IDLE.
    spike_in    = 4'b0101;
    spike_valid = 1'b1;
    while (!spike_ready && w < 50) begin
      if (data_valid) begin
        got0 = 1'b1;
        d0   = data_out;
      end
      step();
      w++;
    end
    step();
    acc1        = cyc;
    spike_valid = 1'b0;
    spike_in    = '0;
    checks++;
    if (got0 !== 1'b1 || d0 !== 8'd0) begin
      errors++; $display("FAIL zero_train valid=%0b data_out=%0d required valid=1 data_out=0", got0, d0);
    end
    checks++;
    if (acc1 - acc0 != 6) begin
      errors++; $display("FAIL b2b_spacing got %0d required 6", acc1 - acc0);
    end
    wait_valid(acc1, lat);
    checks++;
    if (data_out !== 8'd16) begin
      errors++; $display("FAIL b2b_data_out got %0d required 16", data_out);
    end
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL b2b_latency got %0d required 4", lat);
    end
    step();
  endtask

  task automatic test_stall();
    int acc, acc2, lat;
    logic stable = 1'b1;
    data_ready = 1'b0;
    offer(4'b1111, acc);
    wait_valid(acc, lat);
    spike_in    = 4'b0001;
    spike_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (data_out !== 8'd32 || data_valid !== 1'b1 || spike_ready !== 1'b0) stable = 1'b0;
      step();
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++; $display("FAIL stall_stable got %0b required 1", stable);
    end
    checks++;
    if (data_out !== 8'd32 || data_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hold data_out=%0d valid=%0b required 32/1", data_out, data_valid);
    end
    data_ready = 1'b1;
    step();
    checks++;
    if (data_valid !== 1'b0 || spike_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release valid=%0b spike_ready=%0b required 0/1", data_valid, spike_ready);
    end
    checks++;
    if (data_out !== 8'd32) begin
      errors++; $display("FAIL stall_keep_data got %0d required 32", data_out);
    end
    step();
    acc2        = cyc;
    spike_valid = 1'b0;
    spike_in    = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL stall_next_accept busy=%0b required 1", busy);
    end
    wait_valid(acc2, lat);
    checks++;
    if (data_out !== 8'd8) begin
      errors++; $display("FAIL stall_next_data got %0d required 8", data_out);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int acc, lat;
    logic seen = 1'b0;
    data_ready = 1'b1;
    offer(4'b1111, acc);
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'd0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL abort_outputs data_out=%0d valid=%0b required 0/0", data_out, data_valid);
    end
    checks++;
    if (spike_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state spike_ready=%0b busy=%0b required 1/0", spike_ready, busy);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (data_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_output got %0b required 0", seen);
    end
    offer(4'b0011, acc);
    wait_valid(acc, lat);
    checks++;
    if (data_out !== 8'd16) begin
      errors++; $display("FAIL abort_next_data got %0d required 16", data_out);
    end
    step();
  endtask

  task automatic run_narrow(input logic [3:0] s, output logic [4:0] d, output logic ok);
    int w = 0;
    n_spike_in    = s;
    n_spike_valid = 1'b1;
    while (!n_spike_ready && w < 50) begin
      step();
      w++;
    end
    step();
    n_spike_valid = 1'b0;
    w = 0;
    while (!n_data_valid && w < 50) begin
      step();
      w++;
    end
    ok = n_data_valid;
    d  = n_data_out;
    step();
  endtask

  task automatic test_out_width();
    logic [4:0] d;
    logic ok;
    run_narrow(4'b1111, d, ok);
    checks++;
    if (ok !== 1'b1 || d !== 5'(NARROW_1111)) begin
      errors++; $display("FAIL narrow_1111 valid=%0b data_out=%0d required 1/%0d", ok, d, NARROW_1111);
    end
    run_narrow(4'b0111, d, ok);
    checks++;
    if (ok !== 1'b1 || d !== 5'd24) begin
      errors++; $display("FAIL narrow_0111 valid=%0b data_out=%0d required 1/24", ok, d);
    end
  endtask

  task automatic test_random();
    int expq[$];
    int sent = 0;
    int recvd = 0;
    int exp_v;
    logic pending = 1'b0;
    logic [3:0] cur = '0;
    spike_valid = 1'b0;
    for (int c = 0; c < 20000 && recvd < 200; c++) begin
      if (!pending) begin
        if (sent < 200 && $urandom_range(0, 2) != 0) begin
          cur         = 4'($urandom);
          spike_in    = cur;
          spike_valid = 1'b1;
          pending     = 1'b1;
        end else begin
          spike_valid = 1'b0;
          spike_in    = 4'($urandom);
        end
      end
      data_ready = ($urandom_range(0, 3) != 0);
      if (spike_valid && spike_ready) begin
        expq.push_back($countones(cur) * 8);
        sent++;
        pending = 1'b0;
      end
      if (data_valid && data_ready) begin
        exp_v = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++;
        if (int'(data_out) != exp_v) begin
          errors++; $display("FAIL random_train_%0d got %0d required %0d", recvd, data_out, exp_v);
        end
        recvd++;
      end
      step();
    end
    spike_valid = 1'b0;
    data_ready  = 1'b1;
    checks++;
    if (recvd != 200) begin
      errors++; $display("FAIL random_count got %0d required 200", recvd);
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL random_leftover got %0d required 0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_out_width();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
